// File: rtl/pong_pkg.sv
//----------------------------------------------------------------------
// pong_pkg : shared geometry defaults and paddle FSM state encoding
// Rev 1.0  : initial release
//----------------------------------------------------------------------
`default_nettype none

package pong_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int BIT_WIDTH_DEF  = 3;
  localparam int PADDLE_LEN_DEF = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD_L   = 3'd1,
    HOLD_R   = 3'd2,
    REPEAT_L = 3'd3,
    REPEAT_R = 3'd4
  } paddle_state_e;

endpackage : pong_pkg

`default_nettype wire

// File: rtl/button_debouncer.sv
//----------------------------------------------------------------------
// button_debouncer : 2-flop synchronizer followed by a level debouncer
// Rev 1.0          : initial release
//----------------------------------------------------------------------
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Any cycle agreeing with the accepted level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;

endmodule : button_debouncer

`default_nettype wire

// File: rtl/paddle_controller.sv
//----------------------------------------------------------------------
// paddle_controller : debounced two-button paddle with hold/auto-repeat
// Rev 1.0           : initial release
//----------------------------------------------------------------------
`default_nettype none

module paddle_controller
  import pong_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int BIT_WIDTH       = BIT_WIDTH_DEF,
  parameter int PADDLE_LEN      = PADDLE_LEN_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 tick,
  input  logic                 en,
  output logic [BIT_WIDTH-1:0] state_left,
  output logic [BIT_WIDTH-1:0] state_right,
  output logic                 at_left_edge,
  output logic                 at_right_edge
);

  localparam int RPT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RPT_W-1:0]     RPT_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [BIT_WIDTH-1:0] POS_ONE   = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0] RST_LEFT  = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2);
  localparam logic [BIT_WIDTH-1:0] RST_RIGHT = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2 + PADDLE_LEN - 1);
  localparam logic [BIT_WIDTH-1:0] MAX_POS   = BIT_WIDTH'(WIDTH - 1);

  logic db_left, db_right;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_left),
    .btn_level (db_left)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_right),
    .btn_level (db_right)
  );

  paddle_state_e        state_q, state_d;
  logic [RPT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [BIT_WIDTH-1:0] left_q, left_d;
  logic [BIT_WIDTH-1:0] right_q, right_d;
  logic                 step_l, step_r;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    step_l     = 1'b0;
    step_r     = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_cnt_d = '0;
          if (db_left && !db_right) begin
            step_l  = 1'b1;
            state_d = HOLD_L;
          end else if (db_right && !db_left) begin
            step_r  = 1'b1;
            state_d = HOLD_R;
          end
        end
        HOLD_L, HOLD_R: begin
          if ((state_q == HOLD_L) ? (!db_left || db_right) : (!db_right || db_left)) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (tick) begin
            if (hold_cnt_q == RPT_LAST) begin
              state_d    = (state_q == HOLD_L) ? REPEAT_L : REPEAT_R;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + RPT_W'(1);
            end
          end
        end
        REPEAT_L: begin
          if (!db_left || db_right) state_d = IDLE;
          else                      step_l  = tick;
        end
        REPEAT_R: begin
          if (!db_right || db_left) state_d = IDLE;
          else                      step_r  = tick;
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Steps into a wall are swallowed so the paddle length never changes.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (step_l && (left_q != '0)) begin
      left_d  = left_q - POS_ONE;
      right_d = right_q - POS_ONE;
    end else if (step_r && (right_q != MAX_POS)) begin
      left_d  = left_q + POS_ONE;
      right_d = right_q + POS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      left_q     <= RST_LEFT;
      right_q    <= RST_RIGHT;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign state_left    = left_q;
  assign state_right   = right_q;
  assign at_left_edge  = (left_q == '0);
  assign at_right_edge = (right_q == MAX_POS);

endmodule : paddle_controller

`default_nettype wire

// File: tb/tb_paddle_controller.sv
//----------------------------------------------------------------------
// tb_paddle_controller : directed self-checking bench for paddle_controller
// Rev 1.0              : initial release
//----------------------------------------------------------------------
`default_nettype none

module tb_paddle_controller;

  logic       clk;
  logic       rst_n;
  logic       btn_left;
  logic       btn_right;
  logic       tick;
  logic       en;
  logic [2:0] state_left;
  logic [2:0] state_right;
  logic       at_left_edge;
  logic       at_right_edge;

  int checks = 0;
  int errors = 0;

  paddle_controller #(
    .WIDTH           (8),
    .BIT_WIDTH       (3),
    .PADDLE_LEN      (3),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .tick          (tick),
    .en            (en),
    .state_left    (state_left),
    .state_right   (state_right),
    .at_left_edge  (at_left_edge),
    .at_right_edge (at_right_edge)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int l, input int r, input int le, input int re);
    chk({tag, ".left"},  int'(state_left),    l);
    chk({tag, ".right"}, int'(state_right),   r);
    chk({tag, ".ledge"}, int'(at_left_edge),  le);
    chk({tag, ".redge"}, int'(at_right_edge), re);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n     = 1'b1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    tick      = 1'b0;
    en        = 1'b1;
    step(1);

    // Asynchronous reset: takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_pos("reset_async", 2, 4, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(20);
    chk_pos("idle20", 2, 4, 0, 0);

    // Right press: exact latency 2 sync + 4 debounce + 1 FSM edge.
    btn_right = 1'b1;
    step(6);
    chk_pos("right_lat_before", 2, 4, 0, 0);
    step(1);
    chk_pos("right_first_step", 3, 5, 0, 0);
    step(5);
    chk_pos("right_held_no_tick", 3, 5, 0, 0);
    btn_right = 1'b0;
    step(8);
    chk_pos("right_released", 3, 5, 0, 0);

    // Hold then auto-repeat to the right wall.
    do_reset();
    btn_right = 1'b1;
    step(7);
    chk_pos("rpt_press", 3, 5, 0, 0);
    pulse_tick();
    chk_pos("rpt_tick1", 3, 5, 0, 0);
    pulse_tick();
    chk_pos("rpt_tick2", 3, 5, 0, 0);
    pulse_tick();
    chk_pos("rpt_tick3", 3, 5, 0, 0);
    pulse_tick();
    chk_pos("rpt_tick4", 4, 6, 0, 0);
    pulse_tick();
    chk_pos("rpt_tick5", 5, 7, 0, 1);
    pulse_tick();
    chk_pos("rpt_tick6_wall", 5, 7, 0, 1);
    btn_right = 1'b0;
    step(8);

    // Short glitch on left is rejected.
    do_reset();
    btn_left = 1'b1;
    step(3);
    btn_left = 1'b0;
    step(10);
    chk_pos("glitch", 2, 4, 0, 0);

    // Both buttons: no move; dropping right lets left act as a new press.
    btn_left  = 1'b1;
    btn_right = 1'b1;
    step(10);
    chk_pos("both_held", 2, 4, 0, 0);
    btn_right = 1'b0;
    step(6);
    chk_pos("both_rel_before", 2, 4, 0, 0);
    step(1);
    chk_pos("both_rel_left_step", 1, 3, 0, 0);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk_pos("left_hold3", 1, 3, 0, 0);
    pulse_tick();
    chk_pos("left_repeat", 0, 2, 1, 0);
    pulse_tick();
    chk_pos("left_wall", 0, 2, 1, 0);
    btn_left = 1'b0;
    step(8);

    // Enable low freezes; re-enable with button held steps at once.
    do_reset();
    btn_left = 1'b1;
    step(7);
    chk_pos("en_press", 1, 3, 0, 0);
    en = 1'b0;
    pulse_tick();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk_pos("en_frozen", 1, 3, 0, 0);
    en = 1'b1;
    step(1);
    chk_pos("en_resume", 0, 2, 1, 0);

    // Reset mid-hold: held button must fully re-debounce.
    #2 rst_n = 1'b0;
    #1;
    chk_pos("midhold_reset", 2, 4, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk_pos("midhold_before", 2, 4, 0, 0);
    step(1);
    chk_pos("midhold_step", 1, 3, 0, 0);
    btn_left = 1'b0;
    step(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_paddle_controller

`default_nettype wire
